// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// loader state encoding and frame geometry constants.
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned INSTR_WIDTH    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: takes a framed byte stream (16-bit word count, big-endian
// words, XOR checksum) and writes it into instruction memory, stalling the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_data_i,
    output logic                   byte_ready_o,
    output logic                   imem_we_o,
    output logic [ADDR_WIDTH-1:0]  imem_waddr_o,
    output logic [INSTR_WIDTH-1:0] imem_wdata_o,
    output logic                   cpu_hold_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [ADDR_WIDTH:0]    word_count_o
);

    loader_state_e state_q, state_d;

    logic [7:0]             countHi_q;
    logic [15:0]            count_q;
    logic [7:0]             acc_q;
    logic [23:0]            asmWord_q;
    logic [1:0]             byteIdx_q;
    logic [ADDR_WIDTH:0]    wordCount_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [INSTR_WIDTH-1:0] wdata_q;

    logic        xfer;
    logic        startAccept;
    logic        wordComplete;
    logic        lastWord;
    logic [15:0] headerWords;

    assign xfer         = byte_valid_i && byte_ready_o;
    assign startAccept  = start_i && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign wordComplete = (byteIdx_q == 2'(BYTES_PER_WORD - 1));
    assign lastWord     = (32'(wordCount_q) + 32'd1) == 32'(count_q);
    assign headerWords  = {countHi_q, byte_data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (xfer) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    if ({16'd0, headerWords} > MAX_WORDS) state_d = ST_ERR;
                    else if (headerWords == 16'd0)        state_d = ST_CHK;
                    else                                  state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer && wordComplete && lastWord) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (xfer) state_d = (byte_data_i == acc_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready_o = 1'b0;
        cpu_hold_o   = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (state_q)
            ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
            end
            ST_DONE: done_o = 1'b1;
            ST_ERR: begin
                error_o    = 1'b1;
                cpu_hold_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: header capture, checksum, word assembly and the one-cycle write strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            countHi_q   <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            asmWord_q   <= '0;
            byteIdx_q   <= '0;
            wordCount_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (startAccept) begin
                countHi_q   <= '0;
                count_q     <= '0;
                acc_q       <= '0;
                byteIdx_q   <= '0;
                wordCount_q <= '0;
            end else if (xfer) begin
                case (state_q)
                    ST_HDR_HI: begin
                        countHi_q <= byte_data_i;
                        acc_q     <= acc_q ^ byte_data_i;
                    end
                    ST_HDR_LO: begin
                        count_q <= headerWords;
                        acc_q   <= acc_q ^ byte_data_i;
                    end
                    ST_DATA: begin
                        asmWord_q <= {asmWord_q[15:0], byte_data_i};
                        acc_q     <= acc_q ^ byte_data_i;
                        byteIdx_q <= byteIdx_q + 2'd1;
                        if (wordComplete) begin
                            we_q        <= 1'b1;
                            waddr_q     <= wordCount_q[ADDR_WIDTH-1:0];
                            wdata_q     <= {asmWord_q, byte_data_i};
                            wordCount_q <= wordCount_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_waddr_o = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = wordCount_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames compared
// against a frame-level reference model of the expected writes and status.
module tb_imem_loader;

    localparam int AW   = 8;
    localparam int MAXW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          byteValid = 1'b0;
    logic [7:0]    byteData = 8'h00;
    logic          byteReady;
    logic          imemWe;
    logic [AW-1:0] imemWaddr;
    logic [31:0]   imemWdata;
    logic          cpuHold;
    logic          done;
    logic          error;
    logic [AW:0]   wordCount;

    int totalChecks = 0;
    int passChecks  = 0;
    int failChecks  = 0;

    logic [7:0]  frame[$];
    int          wAddr[$];
    logic [31:0] wData[$];

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .byte_valid_i (byteValid),
        .byte_data_i  (byteData),
        .byte_ready_o (byteReady),
        .imem_we_o    (imemWe),
        .imem_waddr_o (imemWaddr),
        .imem_wdata_o (imemWdata),
        .cpu_hold_o   (cpuHold),
        .done_o       (done),
        .error_o      (error),
        .word_count_o (wordCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imemWe === 1'b1) begin
            wAddr.push_back(int'(imemWaddr));
            wData.push_back(imemWdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        assert (obs === exp) passChecks++;
        else begin
            failChecks++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        byteValid = 1'b1;
        byteData  = b;
        guard     = 0;
        while (byteReady !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("byteAccept", byteReady, 1);
        if (byteReady === 1'b1) begin
            @(posedge clk); #1;
        end
        byteValid = 1'b0;
    endtask

    task automatic runFrame(input int gapMax);
        pulseStart();
        foreach (frame[i])
            applyStimulus(frame[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Frame-level reference: parse header, slice payload into words, XOR everything.
    task automatic verifyFrame(input string tag);
        int          n;
        logic [7:0]  x;
        logic [31:0] word;
        bit          oversize;
        bit          good;
        int          nCheck;
        n        = {frame[0], frame[1]};
        oversize = (n > MAXW);
        good     = 1'b0;
        if (oversize) begin
            n = 0;
        end else begin
            x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame[i];
            good = (frame[2 + 4 * n] == x);
        end
        checkOutput({tag, ".writes"}, wData.size(), n);
        nCheck = (wData.size() < n) ? wData.size() : n;
        for (int i = 0; i < nCheck; i++) begin
            word = {frame[2 + 4 * i], frame[3 + 4 * i], frame[4 + 4 * i], frame[5 + 4 * i]};
            checkOutput({tag, ".waddr"}, wAddr[i], i);
            checkOutput({tag, ".wdata"}, wData[i], word);
        end
        checkOutput({tag, ".done"},      done,      good);
        checkOutput({tag, ".error"},     error,     !good);
        checkOutput({tag, ".cpuHold"},   cpuHold,   !good);
        checkOutput({tag, ".byteReady"}, byteReady, 0);
        checkOutput({tag, ".wordCount"}, wordCount, n);
        wAddr.delete();
        wData.delete();
    endtask

    task automatic buildRandomFrame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
        end
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(corrupt ? ~x : x);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".byteReady"}, byteReady, 0);
        checkOutput({tag, ".imemWe"},    imemWe,    0);
        checkOutput({tag, ".imemWaddr"}, imemWaddr, 0);
        checkOutput({tag, ".imemWdata"}, imemWdata, 0);
        checkOutput({tag, ".cpuHold"},   cpuHold,   0);
        checkOutput({tag, ".done"},      done,      0);
        checkOutput({tag, ".error"},     error,     0);
        checkOutput({tag, ".wordCount"}, wordCount, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("idle");

        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
        runFrame(0);
        checkOutput("good.word0", (wData.size() > 0) ? wData[0] : 32'h0, 32'h20080005);
        checkOutput("good.word1", (wData.size() > 1) ? wData[1] : 32'h0, 32'h2009000A);
        verifyFrame("good");

        frame[10] = 8'hFF;
        runFrame(0);
        verifyFrame("badChk");

        frame = '{8'h00, 8'h00, 8'h00};
        runFrame(0);
        verifyFrame("empty");

        frame = '{8'h01, 8'h01};
        runFrame(0);
        verifyFrame("oversize");
        byteValid = 1'b1;
        byteData  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("oversize.stillBlocked", byteReady, 0);
        checkOutput("oversize.stillError",   error,     1);
        byteValid = 1'b0;

        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
        runFrame(5);
        verifyFrame("backpressure");

        // Abort mid-payload with an asynchronous reset, then reload cleanly.
        pulseStart();
        for (int i = 0; i < 7; i++) applyStimulus(frame[i], 0);
        rst = 1'b1;
        #1;
        checkResetOutputs("midReset");
        @(posedge clk); #1;
        rst = 1'b0;
        wAddr.delete();
        wData.delete();
        runFrame(2);
        verifyFrame("afterReset");

        frame = '{8'h00, 8'h01, 8'h3C, 8'h01, 8'h10, 8'h00, 8'h2C};
        runFrame(0);
        checkOutput("restart.word0", (wData.size() > 0) ? wData[0] : 32'h0, 32'h3C011000);
        verifyFrame("restart");

        // A start mid-frame must not restart the header parse.
        frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        frame[6] = 8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
        pulseStart();
        for (int i = 0; i < 3; i++) applyStimulus(frame[i], 0);
        pulseStart();
        for (int i = 3; i < 7; i++) applyStimulus(frame[i], 0);
        repeat (2) @(posedge clk);
        #1;
        verifyFrame("startIgnored");

        buildRandomFrame(MAXW, 1'b0);
        runFrame(0);
        checkOutput("maxWords.lastAddr", (wAddr.size() == MAXW) ? wAddr[MAXW - 1] : -1, MAXW - 1);
        verifyFrame("maxWords");

        for (int t = 0; t < 10; t++) begin
            buildRandomFrame(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
            runFrame(3);
            verifyFrame("random");
        end

        $display("[TB] %0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
